// File: rtl/gcd_arbiter.sv
// gcd_arbiter: round-robin front end that shares one GCD core between NREQ
// requesters. A winner's operands are latched, the core is started with a
// one-cycle go pulse, and the core result is returned with a one-hot,
// one-cycle acknowledge. Zero operands bypass the core entirely.
//
// Optional feature: define GCD_ARB_TIMEOUT_EN to build a watchdog that ends a
// WAIT lasting TIMEOUT_CYCLES cycles with result=0 and err=1. Without the
// macro no counter exists, err is tied low and WAIT waits indefinitely.
module gcd_arbiter #(
  parameter int NREQ           = 4,
  parameter int WIDTH          = 4,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NREQ-1:0]           req,
  input  logic [NREQ*WIDTH-1:0]     x_in,
  input  logic [NREQ*WIDTH-1:0]     y_in,
  output logic [NREQ-1:0]           ack,
  output logic [WIDTH-1:0]          result,
  output logic                      err,
  output logic                      busy,
  output logic [$clog2(NREQ)-1:0]   grant_id,
  output logic [WIDTH-1:0]          gcd_x,
  output logic [WIDTH-1:0]          gcd_y,
  output logic                      gcd_go,
  input  logic                      gcd_done,
  input  logic [WIDTH-1:0]          gcd_result
);

  localparam int GW = $clog2(NREQ);

  // Parameter sanity guards, evaluated at elaboration only.
  if (NREQ < 2 || NREQ > 8) begin : g_bad_nreq
    $error("gcd_arbiter: NREQ must be in 2..8");
  end
  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("gcd_arbiter: TIMEOUT_CYCLES must be at least 1");
  end

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LAUNCH = 2'd1,
    WAIT   = 2'd2,
    RESP   = 2'd3
  } state_t;

  state_t          state;
  logic            armed;
  logic [GW-1:0]   last_grant;

  logic [GW-1:0]    win_id;
  logic [WIDTH-1:0] win_x;
  logic [WIDTH-1:0] win_y;
  logic             win_zero;
  logic             req_any;

`ifdef GCD_ARB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] wait_cnt;
`endif

  // First asserted request at or after last+1, wrapping modulo NREQ.
  function automatic logic [GW-1:0] rr_pick(input logic [NREQ-1:0] r,
                                            input logic [GW-1:0]   last);
    logic [GW-1:0] sel;
    logic [GW-1:0] cand;
    logic          found;
    int            pos;
    sel   = last;
    found = 1'b0;
    for (int k = 1; k <= NREQ; k++) begin
      pos  = (int'(last) + k) % NREQ;
      cand = GW'(pos);
      if (!found && r[cand]) begin
        sel   = cand;
        found = 1'b1;
      end
    end
    return sel;
  endfunction

  // One-hot acknowledge vector for requester id.
  function automatic logic [NREQ-1:0] one_hot(input logic [GW-1:0] id);
    logic [NREQ-1:0] v;
    v     = '0;
    v[id] = 1'b1;
    return v;
  endfunction

  // Arbitration and operand selection for the requester that would win now.
  always_comb begin
    req_any = |req;
    win_id  = rr_pick(req, last_grant);
    win_x   = '0;
    win_y   = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (GW'(i) == win_id) begin
        win_x = x_in[i*WIDTH +: WIDTH];
        win_y = y_in[i*WIDTH +: WIDTH];
      end
    end
    win_zero = (win_x == '0) || (win_y == '0);
  end

  // Scheduler FSM; every output is a register written on state transitions.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      armed      <= 1'b0;
      last_grant <= GW'(NREQ - 1);
      ack        <= '0;
      result     <= '0;
      busy       <= 1'b0;
      grant_id   <= '0;
      gcd_go     <= 1'b0;
      gcd_x      <= '0;
      gcd_y      <= '0;
`ifdef GCD_ARB_TIMEOUT_EN
      err        <= 1'b0;
      wait_cnt   <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (req_any) begin
            grant_id <= win_id;
            gcd_x    <= win_x;
            gcd_y    <= win_y;
            busy     <= 1'b1;
            if (win_zero) begin
              // gcd(0,a)=a and gcd(0,0)=0, so x|y is the answer directly.
              result <= win_x | win_y;
              ack    <= one_hot(win_id);
              state  <= RESP;
            end else begin
              gcd_go <= 1'b1;
              state  <= LAUNCH;
            end
          end
        end
        LAUNCH: begin
          gcd_go <= 1'b0;
          armed  <= 1'b0;
`ifdef GCD_ARB_TIMEOUT_EN
          wait_cnt <= '0;
`endif
          state  <= WAIT;
        end
        WAIT: begin
          // done must be seen low once before a high level is trusted;
          // a level left over from the previous operation is ignored.
          if (!gcd_done) begin
            armed <= 1'b1;
          end
          if (gcd_done && armed) begin
            result <= gcd_result;
            ack    <= one_hot(grant_id);
            state  <= RESP;
          end
`ifdef GCD_ARB_TIMEOUT_EN
          else if (wait_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
            result <= '0;
            err    <= 1'b1;
            ack    <= one_hot(grant_id);
            state  <= RESP;
          end else begin
            wait_cnt <= wait_cnt + TW'(1);
          end
`endif
        end
        RESP: begin
          ack        <= '0;
          busy       <= 1'b0;
          last_grant <= grant_id;
`ifdef GCD_ARB_TIMEOUT_EN
          err        <= 1'b0;
`endif
          state      <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

`ifndef GCD_ARB_TIMEOUT_EN
  // No watchdog in this build, so there is never an error to report.
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_gcd_arbiter.sv
// Testbench for gcd_arbiter: behavioural GCD core, round-robin reference
// model and Euclid reference, with randomized rounds plus directed scenarios.
module tb_gcd_arbiter;

  localparam int NREQ  = 4;
  localparam int WIDTH = 4;
  localparam int TO    = 64;
  localparam int GW    = 2;

  logic                  clk = 1'b0;
  logic                  reset;
  logic [NREQ-1:0]       req;
  logic [NREQ*WIDTH-1:0] x_in;
  logic [NREQ*WIDTH-1:0] y_in;
  logic [NREQ-1:0]       ack;
  logic [WIDTH-1:0]      result;
  logic                  err;
  logic                  busy;
  logic [GW-1:0]         grant_id;
  logic [WIDTH-1:0]      gcd_x;
  logic [WIDTH-1:0]      gcd_y;
  logic                  gcd_go;
  logic                  gcd_done;
  logic [WIDTH-1:0]      gcd_result;

  gcd_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset(reset), .req(req), .x_in(x_in), .y_in(y_in),
    .ack(ack), .result(result), .err(err), .busy(busy), .grant_id(grant_id),
    .gcd_x(gcd_x), .gcd_y(gcd_y), .gcd_go(gcd_go),
    .gcd_done(gcd_done), .gcd_result(gcd_result)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_pass   = 0;

  // Euclid reference, with gcd(0,a)=a.
  function automatic logic [WIDTH-1:0] ref_gcd(input logic [WIDTH-1:0] a,
                                               input logic [WIDTH-1:0] b);
    int x, y, t;
    x = a; y = b;
    while (y != 0) begin
      t = x % y; x = y; y = t;
    end
    return WIDTH'(x);
  endfunction

  // Behavioural core: t counts cycles since the go edge; done is held high
  // for core_hold cycles (stale level), then low, then high from core_lat on.
  int core_lat  = 3;
  int core_hold = 0;
  bit core_dead = 1'b0;
  int ct        = 0;
  bit cact      = 1'b0;
  logic [WIDTH-1:0] res_new = '0;
  logic [WIDTH-1:0] res_old = '0;

  always @(posedge clk) begin
    if (gcd_go === 1'b1) begin
      ct      <= 1;
      cact    <= 1'b1;
      res_new <= ref_gcd(gcd_x, gcd_y);
      res_old <= gcd_result;
    end else if (cact && ct < 100000) begin
      ct <= ct + 1;
    end
  end

  assign gcd_done   = cact ? ((ct <= core_hold) ? 1'b1 : (!core_dead && ct >= core_lat)) : 1'b0;
  assign gcd_result = (cact && !core_dead && ct > core_hold && ct >= core_lat) ? res_new : res_old;

  // Operand table mirrored in the bench.
  logic [WIDTH-1:0] opx [NREQ];
  logic [WIDTH-1:0] opy [NREQ];

  task automatic set_ops(input int i, input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
    opx[i] = x;
    opy[i] = y;
    x_in[i*WIDTH +: WIDTH] = x;
    y_in[i*WIDTH +: WIDTH] = y;
  endtask

  // Round-robin reference: expected grant order.
  int model_last = NREQ - 1;
  int exp_id[$];

  task automatic model_order(input logic [NREQ-1:0] pend, input logic [NREQ-1:0] hold, input int n);
    logic [NREQ-1:0] p;
    int pick;
    p = pend;
    exp_id.delete();
    for (int g = 0; g < n; g++) begin
      pick = -1;
      for (int k = 1; k <= NREQ; k++) begin
        if (pick < 0 && p[(model_last + k) % NREQ]) pick = (model_last + k) % NREQ;
      end
      if (pick >= 0) begin
        exp_id.push_back(pick);
        model_last = pick;
        if (!hold[pick]) p[pick] = 1'b0;
      end
    end
  endtask

  // Observation state filled by serve().
  int               q_id[$];
  logic [WIDTH-1:0] q_res[$];
  logic             q_err[$];
  int               q_cyc[$];
  int               go_cnt;
  int               hot_bad;

  task automatic serve(input int budget, input int n_exp, input logic [NREQ-1:0] hold);
    q_id.delete(); q_res.delete(); q_err.delete(); q_cyc.delete();
    go_cnt  = 0;
    hot_bad = 0;
    for (int k = 0; k < budget && q_id.size() < n_exp; k++) begin
      @(negedge clk);
      if (gcd_go === 1'b1) go_cnt++;
      if (ack !== '0) begin
        if ($countones(ack) != 1) hot_bad++;
        for (int i = 0; i < NREQ; i++) begin
          if (ack[i] === 1'b1) begin
            q_id.push_back(i);
            q_res.push_back(result);
            q_err.push_back(err);
            q_cyc.push_back(cyc);
            if (!hold[i]) req[i] = 1'b0;
          end
        end
      end
    end
  endtask

  int extra_ack;
  task automatic settle(input int n);
    extra_ack = 0;
    repeat (n) begin
      @(negedge clk);
      if (ack !== '0) extra_ack++;
    end
  endtask

  task automatic apply_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    model_last = NREQ - 1;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    n_checks++; if (ack !== '0) $display("FAIL reset_ack: got %0h expected 0", ack); else n_pass++;
    n_checks++; if (result !== '0) $display("FAIL reset_result: got %0h expected 0", result); else n_pass++;
    n_checks++; if (err !== 1'b0) $display("FAIL reset_err: got %0b expected 0", err); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL reset_busy: got %0b expected 0", busy); else n_pass++;
    n_checks++; if (grant_id !== '0) $display("FAIL reset_grant_id: got %0d expected 0", grant_id); else n_pass++;
    n_checks++; if (gcd_go !== 1'b0) $display("FAIL reset_go: got %0b expected 0", gcd_go); else n_pass++;
    n_checks++; if (gcd_x !== '0) $display("FAIL reset_gcd_x: got %0h expected 0", gcd_x); else n_pass++;
    n_checks++; if (gcd_y !== '0) $display("FAIL reset_gcd_y: got %0h expected 0", gcd_y); else n_pass++;
    reset = 1'b0;
    model_last = NREQ - 1;
    settle(2);
  endtask

  task automatic test_single();
    int c0;
    set_ops(0, 4'd12, 4'd8);
    core_lat = 2;
    c0  = cyc;
    req = 4'b0001;
    serve(50, 1, '0);
    settle(3);
    n_checks++; if (q_id.size() != 1) $display("FAIL single_ack_count: got %0d expected 1", q_id.size()); else n_pass++;
    if (q_id.size() == 1) begin
      n_checks++; if (q_id[0] != 0) $display("FAIL single_ack_id: got %0d expected 0", q_id[0]); else n_pass++;
      n_checks++; if (q_res[0] !== 4'd4) $display("FAIL single_result: got %0d expected 4", q_res[0]); else n_pass++;
      n_checks++; if (q_err[0] !== 1'b0) $display("FAIL single_err: got %0b expected 0", q_err[0]); else n_pass++;
      n_checks++; if (q_cyc[0] - c0 != 4) $display("FAIL single_latency: got %0d expected 4", q_cyc[0] - c0); else n_pass++;
    end
    n_checks++; if (go_cnt != 1) $display("FAIL single_go_cycles: got %0d expected 1", go_cnt); else n_pass++;
    n_checks++; if (extra_ack != 0) $display("FAIL single_extra_ack: got %0d expected 0", extra_ack); else n_pass++;
    n_checks++; if (gcd_x !== 4'd12 || gcd_y !== 4'd8) $display("FAIL single_operands_held: got %0d,%0d expected 12,8", gcd_x, gcd_y); else n_pass++;
    model_last = 0;
  endtask

  task automatic test_contention();
    apply_reset();
    set_ops(0, 4'd9, 4'd6);
    set_ops(1, 4'd15, 4'd5);
    set_ops(2, 4'd7, 4'd3);
    set_ops(3, 4'd8, 4'd8);
    core_lat = 3;
    model_order(4'b1111, '0, 4);
    req = 4'b1111;
    serve(200, 4, '0);
    settle(3);
    n_checks++; if (q_id.size() != 4) $display("FAIL contention_count: got %0d expected 4", q_id.size()); else n_pass++;
    for (int g = 0; g < 4 && g < q_id.size(); g++) begin
      n_checks++; if (q_id[g] != exp_id[g]) $display("FAIL contention_order[%0d]: got %0d expected %0d", g, q_id[g], exp_id[g]); else n_pass++;
      n_checks++; if (q_res[g] !== ref_gcd(opx[exp_id[g]], opy[exp_id[g]])) $display("FAIL contention_result[%0d]: got %0d expected %0d", g, q_res[g], ref_gcd(opx[exp_id[g]], opy[exp_id[g]])); else n_pass++;
    end
    n_checks++; if (go_cnt != 4) $display("FAIL contention_go_count: got %0d expected 4", go_cnt); else n_pass++;
    n_checks++; if (hot_bad != 0) $display("FAIL contention_onehot: got %0d bad acks expected 0", hot_bad); else n_pass++;
  endtask

  task automatic test_fairness();
    set_ops(1, 4'd6, 4'd4);
    set_ops(3, 4'd10, 4'd15);
    core_lat = 2;
    model_order(4'b1010, 4'b1010, 4);
    req = 4'b1010;
    serve(200, 4, 4'b1010);
    req = '0;
    settle(3);
    n_checks++; if (q_id.size() != 4) $display("FAIL fairness_count: got %0d expected 4", q_id.size()); else n_pass++;
    for (int g = 0; g < 4 && g < q_id.size(); g++) begin
      n_checks++; if (q_id[g] != exp_id[g]) $display("FAIL fairness_order[%0d]: got %0d expected %0d", g, q_id[g], exp_id[g]); else n_pass++;
      n_checks++; if (q_res[g] !== ref_gcd(opx[exp_id[g]], opy[exp_id[g]])) $display("FAIL fairness_result[%0d]: got %0d expected %0d", g, q_res[g], ref_gcd(opx[exp_id[g]], opy[exp_id[g]])); else n_pass++;
    end
  endtask

  task automatic test_zero_bypass();
    logic [WIDTH-1:0] tx[3] = '{4'd0, 4'd0, 4'd5};
    logic [WIDTH-1:0] ty[3] = '{4'd9, 4'd0, 4'd0};
    int c0;
    for (int t = 0; t < 3; t++) begin
      set_ops(2, tx[t], ty[t]);
      c0  = cyc;
      req = 4'b0100;
      serve(20, 1, '0);
      settle(3);
      n_checks++; if (q_id.size() != 1) $display("FAIL bypass_count[%0d]: got %0d expected 1", t, q_id.size()); else n_pass++;
      if (q_id.size() == 1) begin
        n_checks++; if (q_id[0] != 2) $display("FAIL bypass_id[%0d]: got %0d expected 2", t, q_id[0]); else n_pass++;
        n_checks++; if (q_res[0] !== ref_gcd(tx[t], ty[t])) $display("FAIL bypass_result[%0d]: got %0d expected %0d", t, q_res[0], ref_gcd(tx[t], ty[t])); else n_pass++;
        n_checks++; if (q_cyc[0] - c0 != 1) $display("FAIL bypass_latency[%0d]: got %0d expected 1", t, q_cyc[0] - c0); else n_pass++;
      end
      n_checks++; if (go_cnt != 0) $display("FAIL bypass_go[%0d]: got %0d expected 0", t, go_cnt); else n_pass++;
      model_last = 2;
    end
  endtask

  task automatic test_back_to_back();
    set_ops(0, 4'd0, 4'd3);
    set_ops(1, 4'd0, 4'd5);
    model_order(4'b0011, '0, 2);
    req = 4'b0011;
    serve(30, 2, '0);
    settle(3);
    n_checks++; if (q_id.size() != 2) $display("FAIL b2b_count: got %0d expected 2", q_id.size()); else n_pass++;
    if (q_id.size() == 2) begin
      n_checks++; if (q_id[0] != exp_id[0] || q_id[1] != exp_id[1]) $display("FAIL b2b_order: got %0d,%0d expected %0d,%0d", q_id[0], q_id[1], exp_id[0], exp_id[1]); else n_pass++;
      n_checks++; if (q_cyc[1] - q_cyc[0] != 2) $display("FAIL b2b_spacing: got %0d expected 2", q_cyc[1] - q_cyc[0]); else n_pass++;
      n_checks++; if (q_res[1] !== ref_gcd(opx[exp_id[1]], opy[exp_id[1]])) $display("FAIL b2b_result: got %0d expected %0d", q_res[1], ref_gcd(opx[exp_id[1]], opy[exp_id[1]])); else n_pass++;
    end
  endtask

  task automatic test_stale_done();
    int c0;
    set_ops(0, 4'd6, 4'd9);
    core_lat = 2; core_hold = 0;
    req = 4'b0001;
    serve(50, 1, '0);
    settle(3);
    model_last = 0;
    set_ops(1, 4'd14, 4'd7);
    core_lat = 5; core_hold = 2;
    c0  = cyc;
    req = 4'b0010;
    serve(60, 1, '0);
    settle(3);
    n_checks++; if (q_id.size() != 1) $display("FAIL stale_count: got %0d expected 1", q_id.size()); else n_pass++;
    if (q_id.size() == 1) begin
      n_checks++; if (q_cyc[0] - c0 != core_lat + 2) $display("FAIL stale_latency: got %0d expected %0d", q_cyc[0] - c0, core_lat + 2); else n_pass++;
      n_checks++; if (q_res[0] !== ref_gcd(4'd14, 4'd7)) $display("FAIL stale_result: got %0d expected %0d", q_res[0], ref_gcd(4'd14, 4'd7)); else n_pass++;
    end
    core_hold = 0;
    model_last = 1;
  endtask

  task automatic test_reset_mid_wait();
    int acks;
    acks = 0;
    set_ops(2, 4'd9, 4'd6);
    core_dead = 1'b1;
    core_lat  = 3;
    req = 4'b0100;
    repeat (4) begin
      @(negedge clk);
      if (ack !== '0) acks++;
    end
    n_checks++; if (busy !== 1'b1) $display("FAIL midwait_busy: got %0b expected 1", busy); else n_pass++;
    reset = 1'b1;
    @(negedge clk);
    if (ack !== '0) acks++;
    n_checks++; if (acks != 0) $display("FAIL midwait_no_ack: got %0d expected 0", acks); else n_pass++;
    n_checks++; if (busy !== 1'b0 || gcd_go !== 1'b0 || ack !== '0) $display("FAIL midwait_reset_ctrl: got busy=%0b go=%0b ack=%0h expected 0", busy, gcd_go, ack); else n_pass++;
    n_checks++; if (gcd_x !== '0 || gcd_y !== '0 || result !== '0 || grant_id !== '0) $display("FAIL midwait_reset_data: got x=%0d y=%0d r=%0d g=%0d expected 0", gcd_x, gcd_y, result, grant_id); else n_pass++;
    reset = 1'b0;
    model_last = NREQ - 1;
    core_dead = 1'b0;
    serve(50, 1, '0);
    settle(3);
    n_checks++; if (q_id.size() != 1 || q_id[0] != 2) $display("FAIL midwait_rearb: got %0d acks expected one ack[2]", q_id.size()); else n_pass++;
    if (q_id.size() == 1) begin
      n_checks++; if (q_res[0] !== 4'd3) $display("FAIL midwait_result: got %0d expected 3", q_res[0]); else n_pass++;
    end
    model_last = 2;
  endtask

`ifdef GCD_ARB_TIMEOUT_EN
  task automatic test_timeout();
    int c0;
    set_ops(3, 4'd4, 4'd6);
    core_dead = 1'b1;
    c0  = cyc;
    req = 4'b1000;
    serve(TO + 20, 1, '0);
    settle(3);
    n_checks++; if (q_id.size() != 1) $display("FAIL timeout_count: got %0d expected 1", q_id.size()); else n_pass++;
    if (q_id.size() == 1) begin
      n_checks++; if (q_id[0] != 3) $display("FAIL timeout_id: got %0d expected 3", q_id[0]); else n_pass++;
      n_checks++; if (q_err[0] !== 1'b1) $display("FAIL timeout_err: got %0b expected 1", q_err[0]); else n_pass++;
      n_checks++; if (q_res[0] !== '0) $display("FAIL timeout_result: got %0d expected 0", q_res[0]); else n_pass++;
      n_checks++; if (q_cyc[0] - c0 != TO + 2) $display("FAIL timeout_latency: got %0d expected %0d", q_cyc[0] - c0, TO + 2); else n_pass++;
    end
    n_checks++; if (err !== 1'b0) $display("FAIL timeout_err_clears: got %0b expected 0", err); else n_pass++;
    core_dead = 1'b0;
    model_last = 3;
  endtask
`else
  task automatic test_timeout();
    int acks;
    acks = 0;
    set_ops(3, 4'd4, 4'd6);
    core_dead = 1'b1;
    req = 4'b1000;
    repeat (TO + 20) begin
      @(negedge clk);
      if (ack !== '0 || err !== 1'b0) acks++;
    end
    n_checks++; if (acks != 0) $display("FAIL wait_forever_no_ack: got %0d expected 0", acks); else n_pass++;
    n_checks++; if (busy !== 1'b1) $display("FAIL wait_forever_busy: got %0b expected 1", busy); else n_pass++;
    req = '0;
    apply_reset();
    core_dead = 1'b0;
    settle(2);
  endtask
`endif

  task automatic test_random();
    logic [NREQ-1:0] mask;
    int n, exp_go;
    for (int r = 0; r < 8; r++) begin
      mask = NREQ'($urandom_range(1, (1 << NREQ) - 1));
      for (int i = 0; i < NREQ; i++) begin
        set_ops(i, ($urandom_range(0, 4) == 0) ? 4'd0 : WIDTH'($urandom_range(1, 15)),
                   ($urandom_range(0, 4) == 0) ? 4'd0 : WIDTH'($urandom_range(1, 15)));
      end
      core_lat = $urandom_range(2, 6);
      n = $countones(mask);
      model_order(mask, '0, n);
      exp_go = 0;
      foreach (exp_id[g]) if (opx[exp_id[g]] != 0 && opy[exp_id[g]] != 0) exp_go++;
      req = mask;
      serve(400, n, '0);
      settle(3);
      n_checks++; if (q_id.size() != n) $display("FAIL random%0d_count: got %0d expected %0d", r, q_id.size(), n); else n_pass++;
      for (int g = 0; g < n && g < q_id.size(); g++) begin
        n_checks++; if (q_id[g] != exp_id[g]) $display("FAIL random%0d_order[%0d]: got %0d expected %0d", r, g, q_id[g], exp_id[g]); else n_pass++;
        n_checks++; if (q_res[g] !== ref_gcd(opx[exp_id[g]], opy[exp_id[g]])) $display("FAIL random%0d_result[%0d]: got %0d expected %0d", r, g, q_res[g], ref_gcd(opx[exp_id[g]], opy[exp_id[g]])); else n_pass++;
      end
      n_checks++; if (go_cnt != exp_go) $display("FAIL random%0d_go_count: got %0d expected %0d", r, go_cnt, exp_go); else n_pass++;
    end
  endtask

  initial begin
    reset = 1'b1;
    req   = '0;
    x_in  = '0;
    y_in  = '0;
    for (int i = 0; i < NREQ; i++) begin
      opx[i] = '0;
      opy[i] = '0;
    end
    test_reset();
    test_single();
    test_contention();
    test_fairness();
    test_zero_bypass();
    test_back_to_back();
    test_stale_done();
    test_reset_mid_wait();
    test_timeout();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed", n_pass, n_checks);
    $fatal(1);
  end

endmodule
